idelay_tap_scan: RTL and testbench



---
 rtl/adc_cal_pkg.sv | 19 +
 rtl/eye_tracker.sv | 85 ++++++++
 rtl/idelay_tap_scan.sv | 181 ++++++++++++++++++
 tb/tb_idelay_tap_scan.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cal_pkg.sv
// rtl/adc_cal_pkg.sv - shared types and defaults for the IDELAY tap calibration slice
package adc_cal_pkg;

  localparam int         TAP_W_DEF   = 9;
  localparam logic [7:0] PATTERN_DEF = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_CENTER,
    ST_FINAL_LOAD,
    ST_VERIFY,
    ST_DONE
  } state_e;

endpackage

// File: rtl/eye_tracker.sv
// rtl/eye_tracker.sv - passing-run tracking, widest-window selection and centre computation
module eye_tracker
  import adc_cal_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             eval,
  input  logic             pass,
  input  logic             last,
  input  logic [TAP_W-1:0] tap,
  output logic             found,
  output logic [TAP_W-1:0] eye_start,
  output logic [TAP_W-1:0] eye_width,
  output logic [TAP_W-1:0] center
);

  logic             run_open_q, run_open_d;
  logic [TAP_W-1:0] run_start_q, run_start_d;
  logic [TAP_W-1:0] run_end_q, run_end_d;
  logic             found_q, found_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [TAP_W-1:0] best_width_q, best_width_d;
  logic [TAP_W-1:0] run_width;

  always_comb begin
    run_open_d   = run_open_q;
    run_start_d  = run_start_q;
    run_end_d    = run_end_q;
    found_d      = found_q;
    best_start_d = best_start_q;
    best_width_d = best_width_q;
    run_width    = run_end_q - run_start_q;
    if (clear) begin
      run_open_d   = 1'b0;
      run_start_d  = '0;
      run_end_d    = '0;
      found_d      = 1'b0;
      best_start_d = '0;
      best_width_d = '0;
    end else if (eval) begin
      if (pass) begin
        if (!run_open_q) run_start_d = tap;
        run_end_d  = tap;
        run_open_d = 1'b1;
      end
      run_width = run_end_d - run_start_d;
      // The final sweep point closes the run even when it passes; ties keep the earlier window.
      if (run_open_d && (!pass || last)) begin
        if (!found_q || run_width > best_width_q) begin
          found_d      = 1'b1;
          best_start_d = run_start_d;
          best_width_d = run_width;
        end
        run_open_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_open_q   <= 1'b0;
      run_start_q  <= '0;
      run_end_q    <= '0;
      found_q      <= 1'b0;
      best_start_q <= '0;
      best_width_q <= '0;
    end else begin
      run_open_q   <= run_open_d;
      run_start_q  <= run_start_d;
      run_end_q    <= run_end_d;
      found_q      <= found_d;
      best_start_q <= best_start_d;
      best_width_q <= best_width_d;
    end
  end

  assign found     = found_q;
  assign eye_start = best_start_q;
  assign eye_width = best_width_q;
  assign center    = best_start_q + (best_width_q >> 1);

endmodule

// File: rtl/idelay_tap_scan.sv
// rtl/idelay_tap_scan.sv - IDELAY tap sweep FSM: load, settle, sample, pick eye centre, verify readback
module idelay_tap_scan
  import adc_cal_pkg::*;
#(
  parameter int TAP_W      = TAP_W_DEF,
  parameter int MAX_TAP    = 511,
  parameter int STEP       = 8,
  parameter int SETTLE_CYC = 16,
  parameter int SAMPLE_CYC = 64,
  parameter int DATA_W     = 8
) (
  input  logic              clk_div,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] data_in,
  output logic              load,
  output logic [TAP_W-1:0]  cntvalue_out,
  input  logic [TAP_W-1:0]  cntvalue_in,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [TAP_W-1:0]  best_tap,
  output logic [TAP_W-1:0]  eye_start,
  output logic [TAP_W-1:0]  eye_width
);

  localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             load_q, load_d;
  logic [TAP_W-1:0] cntval_q, cntval_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [TAP_W-1:0] best_tap_q, best_tap_d;

  logic             trk_clear;
  logic             trk_found;
  logic [TAP_W-1:0] trk_center;
  logic [TAP_W:0]   tap_next;
  logic             tap_fits;

  assign tap_next = {1'b0, tap_q} + (TAP_W+1)'(STEP);
  assign tap_fits = (tap_next <= (TAP_W+1)'(MAX_TAP));

  eye_tracker #(.TAP_W(TAP_W)) u_eye_tracker (
    .clk       (clk_div),
    .rst       (rst),
    .clear     (trk_clear),
    .eval      (state_q == ST_EVAL),
    .pass      (match_q),
    .last      (!tap_fits),
    .tap       (tap_q),
    .found     (trk_found),
    .eye_start (eye_start),
    .eye_width (eye_width),
    .center    (trk_center)
  );

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    cnt_d      = cnt_q;
    match_d    = match_q;
    load_d     = 1'b0;
    cntval_d   = cntval_q;
    busy_d     = busy_q;
    done_d     = done_q;
    fail_d     = fail_q;
    best_tap_d = best_tap_q;
    trk_clear  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          trk_clear  = 1'b1;
          done_d     = 1'b0;
          fail_d     = 1'b0;
          best_tap_d = '0;
          tap_d      = '0;
          busy_d     = 1'b1;
          load_d     = 1'b1;
          cntval_d   = '0;
          cnt_d      = '0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          match_d = 1'b1;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        match_d = match_q & (data_in == pattern);
        if (cnt_q == CNT_W'(SAMPLE_CYC - 1)) state_d = ST_EVAL;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_EVAL: begin
        if (tap_fits) begin
          tap_d    = tap_next[TAP_W-1:0];
          load_d   = 1'b1;
          cntval_d = tap_next[TAP_W-1:0];
          state_d  = ST_LOAD;
        end else begin
          state_d = ST_CENTER;
        end
      end
      ST_CENTER: begin
        if (!trk_found) begin
          fail_d     = 1'b1;
          best_tap_d = '0;
        end else begin
          best_tap_d = trk_center;
        end
        load_d   = 1'b1;
        cntval_d = best_tap_d;
        cnt_d    = '0;
        state_d  = ST_FINAL_LOAD;
      end
      ST_FINAL_LOAD: begin
        // One load cycle followed by SETTLE_CYC idle cycles before readback.
        if (cnt_q == CNT_W'(SETTLE_CYC)) state_d = ST_VERIFY;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_VERIFY: begin
        if (cntvalue_in != best_tap_q) fail_d = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_div) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tap_q      <= '0;
      cnt_q      <= '0;
      match_q    <= 1'b0;
      load_q     <= 1'b0;
      cntval_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      best_tap_q <= '0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      load_q     <= load_d;
      cntval_q   <= cntval_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      best_tap_q <= best_tap_d;
    end
  end

  assign load         = load_q;
  assign cntvalue_out = cntval_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign best_tap     = best_tap_q;

endmodule

// File: tb/tb_idelay_tap_scan.sv
// tb/tb_idelay_tap_scan.sv - randomized and directed bench with an IDELAY lane model and eye reference model
module tb_idelay_tap_scan;
  import adc_cal_pkg::*;

  localparam int TAP_W      = 9;
  localparam int MAX_TAP    = 511;
  localparam int STEP       = 8;
  localparam int SETTLE_CYC = 16;
  localparam int SAMPLE_CYC = 64;
  localparam int DATA_W     = 8;
  localparam int NPTS       = MAX_TAP / STEP + 1;
  localparam int PER        = 1 + SETTLE_CYC + SAMPLE_CYC + 1;
  localparam int T_FLOAD    = NPTS * PER + 2;
  localparam int T_DONE     = T_FLOAD + SETTLE_CYC + 2;

  logic              clk;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic [TAP_W-1:0]  cntvalue_out;
  logic [TAP_W-1:0]  cntvalue_in;
  logic              busy;
  logic              done;
  logic              fail;
  logic [TAP_W-1:0]  best_tap;
  logic [TAP_W-1:0]  eye_start;
  logic [TAP_W-1:0]  eye_width;

  idelay_tap_scan #(
    .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .STEP(STEP),
    .SETTLE_CYC(SETTLE_CYC), .SAMPLE_CYC(SAMPLE_CYC), .DATA_W(DATA_W)
  ) dut (
    .clk_div      (clk),
    .rst          (rst),
    .start        (start),
    .pattern      (pattern),
    .data_in      (data_in),
    .load         (load),
    .cntvalue_out (cntvalue_out),
    .cntvalue_in  (cntvalue_in),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .best_tap     (best_tap),
    .eye_start    (eye_start),
    .eye_width    (eye_width)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // scenario description and expected outcome
  logic [511:0] good_mask = '0;
  int rb_off = 0;
  int sc_best = 0, sc_es = 0, sc_ew = 0;
  bit sc_fail = 0;

  // cycle-level expectation
  int cur = 0;
  bit m_busy = 0, m_done = 0, m_fail = 0;
  int m_best = 0, m_es = 0, m_ew = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cur);
    end
  endtask

  function automatic logic [511:0] rng(input logic [511:0] m, input int lo, input int hi);
    logic [511:0] r;
    r = m;
    for (int t = lo; t <= hi && t <= 511; t++) r[t] = 1'b1;
    return r;
  endfunction

  // Widest maximal run of consecutive passing sweep points, earliest on tie.
  function automatic void model_eval(input logic [511:0] gm, input int rbo,
                                     output int best, output int es, output int ew, output bit f);
    bit found;
    int bs, bw, j;
    found = 0; bs = 0; bw = 0;
    for (int i = 0; i < NPTS; i++) begin
      if (gm[i*STEP] && (i == 0 || !gm[(i-1)*STEP])) begin
        j = i;
        while (j + 1 < NPTS && gm[(j+1)*STEP]) j++;
        if (!found || (j - i) * STEP > bw) begin
          found = 1; bs = i * STEP; bw = (j - i) * STEP;
        end
      end
    end
    es = bs; ew = bw;
    best = found ? bs + bw / 2 : 0;
    f = !found || (rbo != 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_fail = 0; m_best = 0; m_es = 0; m_ew = 0; cur = 0;
    end else if (m_busy) begin
      cur++;
      if (cur == T_DONE) begin
        m_busy = 0; m_done = 1; m_fail = sc_fail; m_best = sc_best; m_es = sc_es; m_ew = sc_ew;
      end
    end else if (start) begin
      m_busy = 1; cur = 1; m_done = 0; m_fail = 0; m_best = 0; m_es = 0; m_ew = 0;
    end
  end

  always @(negedge clk) begin : compare
    bit el;
    int ev;
    if (chk_en) begin
      if (m_busy) begin
        el = 0; ev = 0;
        if (cur <= NPTS * PER && (cur - 1) % PER == 0) begin
          el = 1; ev = ((cur - 1) / PER) * STEP;
        end
        if (cur == T_FLOAD) begin
          el = 1; ev = sc_best;
        end
        chk("busy", busy, 1);
        chk("done", done, 0);
        chk("load", load, el);
        if (el) chk("cntvalue_out", cntvalue_out, ev);
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_load", load, 0);
        chk("done_level", done, m_done);
        chk("fail_level", fail, m_fail);
        chk("best_tap", best_tap, m_best);
        chk("eye_start", eye_start, m_es);
        chk("eye_width", eye_width, m_ew);
      end
    end
  end

  // IDELAY lane: loaded tap takes effect through a short pipeline; words are clean only on good taps.
  logic [TAP_W-1:0] pl_val [4];
  bit   [3:0]       pl_ld;
  logic [TAP_W-1:0] eff_tap;
  initial begin : lane
    int off, cpos;
    bit in_win, all_bad;
    for (int s = 0; s < 4; s++) pl_val[s] = '0;
    pl_ld = '0; eff_tap = '0; data_in = '0; cntvalue_in = '0; cpos = 0; all_bad = 0;
    forever begin
      @(negedge clk);
      if (pl_ld[3]) eff_tap = pl_val[3];
      for (int s = 3; s > 0; s--) begin
        pl_val[s] = pl_val[s-1];
        pl_ld[s]  = pl_ld[s-1];
      end
      pl_val[0] = cntvalue_out;
      pl_ld[0]  = load;
      cntvalue_in = eff_tap + TAP_W'(rb_off);
      off = (cur - 1) % PER;
      in_win = m_busy && cur <= NPTS * PER && off >= 1 + SETTLE_CYC && off <= SETTLE_CYC + SAMPLE_CYC;
      if (m_busy && off == 0) begin
        cpos = $urandom_range(SAMPLE_CYC - 1);
        all_bad = ($urandom_range(3) == 0);
      end
      if (!in_win) data_in = DATA_W'($urandom);
      else if (good_mask[eff_tap]) data_in = pattern;
      else if (all_bad || off - (1 + SETTLE_CYC) == cpos)
        data_in = pattern ^ DATA_W'($urandom_range(255, 1));
      else data_in = pattern;
    end
  end

  task automatic run_case(input string nm, input logic [511:0] gm, input int rbo,
                          input logic [DATA_W-1:0] pat, input int p_best, input int p_es,
                          input int p_ew, input int p_fail, input int poke);
    int b, s, w, n;
    bit f;
    good_mask = gm; rb_off = rbo; pattern = pat;
    model_eval(gm, rbo, b, s, w, f);
    sc_best = b; sc_es = s; sc_ew = w; sc_fail = f;
    if (p_best >= 0) begin
      chk({nm, "_model_best"}, b, p_best);
      chk({nm, "_model_start"}, s, p_es);
      chk({nm, "_model_width"}, w, p_ew);
      chk({nm, "_model_fail"}, f, p_fail);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < T_DONE + 100) begin
      @(negedge clk);
      n++;
      start = (n == poke);
    end
    start = 1'b0;
    chk({nm, "_done_cycle"}, n, 5268);
    if (p_best >= 0) begin
      chk({nm, "_best_tap"}, best_tap, p_best);
      chk({nm, "_fail"}, fail, p_fail);
      chk({nm, "_done"}, done, 1);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    logic [511:0] gm;
    int n, nr, lo;
    rst = 1'b1; start = 1'b0; pattern = PATTERN_DEF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_load", load, 0);
    chk("rst_cntvalue_out", cntvalue_out, 0);
    chk("rst_done", done, 0);
    chk("rst_best_tap", best_tap, 0);
    chk_en = 1;

    run_case("eye96", rng('0, 96, 200), 0, PATTERN_DEF, 148, 96, 104, 0, 0);
    run_case("two_win", rng(rng('0, 16, 40), 304, 312), 0, PATTERN_DEF, 28, 16, 24, 0, 777);
    run_case("tie", rng(rng('0, 0, 16), 200, 216), 0, 8'h3C, 8, 0, 16, 0, 0);
    run_case("single", rng('0, 256, 256), 0, PATTERN_DEF, 256, 256, 0, 0, 0);
    run_case("none", '0, 0, PATTERN_DEF, 0, 0, 0, 1, 0);
    run_case("readback", rng('0, 96, 200), 1, PATTERN_DEF, 148, 96, 104, 1, 0);

    // abort mid-run, then reset and start together, then a normal run with a stray start
    good_mask = rng('0, 0, 40); rb_off = 0; pattern = PATTERN_DEF;
    model_eval(good_mask, 0, sc_best, sc_es, sc_ew, sc_fail);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_load", load, 0);
    chk("abort_cntvalue_out", cntvalue_out, 0);
    chk("abort_eye_width", eye_width, 0);
    chk("abort_fail", fail, 0);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    repeat (2) @(negedge clk);
    run_case("after_abort", rng('0, 120, 300), 0, 8'h5A, 208, 120, 176, 0, 2000);

    for (int r = 0; r < 4; r++) begin
      gm = '0;
      if ($urandom_range(1) == 0) begin
        nr = $urandom_range(3, 1);
        for (int q = 0; q < nr; q++) begin
          lo = $urandom_range(511);
          gm = rng(gm, lo, lo + $urandom_range(120));
        end
      end else begin
        for (int i = 0; i < NPTS; i++) gm[i*STEP] = ($urandom_range(2) != 0);
      end
      run_case("random", gm, ($urandom_range(4) == 0) ? 1 : 0, DATA_W'($urandom), -1, -1, -1, -1,
               $urandom_range(4000, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
